// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard frame receiver and scan-code decoder
//
// Purpose: synchronizes and glitch-filters the PS/2 clock, shifts in 11-bit
// frames (start, 8 data LSB first, odd parity, stop), checks framing, and
// decodes make / break (F0) / extended (E0) sequences into a held key value.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   ps2Clk     in   raw PS/2 clock line (asynchronous)
//   ps2Data    in   raw PS/2 data line (asynchronous)
//   keyDown    out  active-low key-held level for the key in value
//   value      out  {prefix, code}, prefix 8'hE0 for extended keys
//   byteValid  out  one-cycle pulse per accepted data byte
//   rxByte     out  last accepted data byte, held between pulses
//   frameError out  one-cycle pulse on start/parity/stop error or timeout
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2Clk,
  input  logic        ps2Data,
  output logic        keyDown,
  output logic [15:0] value,
  output logic        byteValid,
  output logic [7:0]  rxByte,
  output logic        frameError
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_clk_s1, r_clk_s2;
  logic        r_dat_s1, r_dat_s2;
  logic        r_filt, r_filt_d;
  logic [FCW-1:0] r_fcnt;
  logic [TCW-1:0] r_tcnt;
  logic [3:0]  r_bitcnt;
  logic [10:0] r_shift;
  logic        r_e0, r_f0;

  logic        w_fall;
  logic        w_timeout;
  logic        w_frame_ok;
  logic [7:0]  w_code;
  logic [7:0]  w_prefix;

  assign w_fall     = r_filt_d & ~r_filt;
  assign w_code     = r_shift[8:1];
  assign w_prefix   = r_e0 ? 8'hE0 : 8'h00;
  // start low, stop high, data plus parity carries an odd number of ones
  assign w_frame_ok = ~r_shift[0] & r_shift[10] & (^r_shift[9:1]);
  // an edge in the same cycle restarts the count, so it wins over timeout
  assign w_timeout  = (r_state == RECV) && !w_fall &&
                      (r_tcnt == TCW'(TIMEOUT_CYCLES - 1));

  // Input synchronizers and clock glitch filter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_clk_s1 <= ps2Clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2Data;
      r_dat_s2 <= r_dat_s1;
      r_filt_d <= r_filt;
      // count consecutive samples that disagree with the filtered level;
      // any agreeing sample restarts the run
      if (r_clk_s2 == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FCW'(FILTER_LEN - 1)) begin
        r_filt <= r_clk_s2;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_fall) w_next = RECV;
      RECV: begin
        if (w_timeout)                        w_next = IDLE;
        else if (w_fall && r_bitcnt == 4'd10) w_next = CHECK;
      end
      CHECK: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Receive datapath, frame check and decoder
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_tcnt     <= '0;
      r_e0       <= 1'b0;
      r_f0       <= 1'b0;
      keyDown    <= 1'b1;
      value      <= 16'h0000;
      byteValid  <= 1'b0;
      rxByte     <= 8'h00;
      frameError <= 1'b0;
    end else begin
      byteValid  <= 1'b0;
      frameError <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tcnt <= '0;
          if (w_fall) begin
            // first bit enters at the top; ten more shifts land it in bit 0
            r_shift  <= {r_dat_s2, 10'b0};
            r_bitcnt <= 4'd1;
          end
        end
        RECV: begin
          if (w_fall) begin
            r_shift  <= {r_dat_s2, r_shift[10:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
            r_tcnt   <= '0;
          end else if (w_timeout) begin
            frameError <= 1'b1;
            r_bitcnt   <= '0;
            r_tcnt     <= '0;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        CHECK: begin
          r_bitcnt <= '0;
          r_tcnt   <= '0;
          if (w_frame_ok) begin
            byteValid <= 1'b1;
            rxByte    <= w_code;
            if (w_code == 8'hE0) begin
              r_e0 <= 1'b1;
            end else if (w_code == 8'hF0) begin
              r_f0 <= 1'b1;
            end else begin
              if (!r_f0) begin
                value   <= {w_prefix, w_code};
                keyDown <= 1'b0;
              end else if ({w_prefix, w_code} == value) begin
                keyDown <= 1'b1;
              end
              r_e0 <= 1'b0;
              r_f0 <= 1'b0;
            end
          end else begin
            frameError <= 1'b1;
          end
        end
        default: begin
          r_bitcnt <= '0;
          r_tcnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - directed self-checking bench for ps2_keyboard_rx
module tb_ps2_keyboard_rx;

  localparam int TO = 2000;

  logic        clk;
  logic        rst;
  logic        ps2Clk;
  logic        ps2Data;
  logic        keyDown;
  logic [15:0] value;
  logic        byteValid;
  logic [7:0]  rxByte;
  logic        frameError;

  int tests    = 0;
  int failed   = 0;
  int cyc      = 0;
  int bv_count = 0;
  int fe_count = 0;
  int bv_cyc   = 0;
  int fall_cyc = 0;
  int overlap  = 0;
  int bv0, fe0;

  ps2_keyboard_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2Clk     (ps2Clk),
    .ps2Data    (ps2Data),
    .keyDown    (keyDown),
    .value      (value),
    .byteValid  (byteValid),
    .rxByte     (rxByte),
    .frameError (frameError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (byteValid) begin
      bv_count = bv_count + 1;
      bv_cyc   = cyc;
    end
    if (frameError) fe_count = fe_count + 1;
    if (byteValid && frameError) overlap = 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests = tests + 1;
    if (got !== exp) begin
      failed = failed + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // drives bits 0..nbits-1 of frame, data set up while the clock is high
  task automatic send_bits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2Data = frame[i];
      wait_cycles(10);
      ps2Clk   = 1'b0;
      fall_cyc = cyc;
      wait_cycles(20);
      ps2Clk = 1'b1;
    end
    wait_cycles(10);
    ps2Data = 1'b1;
    wait_cycles(20);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad_par);
    logic par;
    par = (~^d) ^ bad_par;
    send_bits({1'b1, par, d, 1'b0}, 11);
  endtask

  initial begin
    rst = 1'b1; ps2Clk = 1'b1; ps2Data = 1'b1;
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(2);
    check("rst_keyDown", keyDown, 1);
    check("rst_value", value, 16'h0000);
    check("rst_rxByte", rxByte, 8'h00);
    check("rst_byteValid", byteValid, 0);
    check("rst_frameError", frameError, 0);

    // make 'A'; raw fall -> 2 sync + 4 filter -> edge N -> N+2 = 8 cycles
    send_byte(8'h1C, 1'b0);
    check("make_bv_count", bv_count, 1);
    check("make_rxByte", rxByte, 8'h1C);
    check("make_keyDown", keyDown, 0);
    check("make_value", value, 16'h001C);
    check("make_latency", bv_cyc - fall_cyc, 8);

    // break 'A'
    send_byte(8'hF0, 1'b0);
    check("f0_rxByte", rxByte, 8'hF0);
    check("f0_keyDown_held", keyDown, 0);
    send_byte(8'h1C, 1'b0);
    check("brk_bv_count", bv_count, 3);
    check("brk_keyDown", keyDown, 1);
    check("brk_value", value, 16'h001C);
    check("brk_fe_count", fe_count, 0);

    // extended up-arrow make and break
    send_byte(8'hE0, 1'b0);
    check("e0_value_unchanged", value, 16'h001C);
    send_byte(8'h75, 1'b0);
    check("ext_make_value", value, 16'hE075);
    check("ext_make_keyDown", keyDown, 0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    check("ext_brk_keyDown", keyDown, 1);
    check("ext_brk_value", value, 16'hE075);

    // break of a key that is not held is ignored
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    check("other_brk_keyDown", keyDown, 0);
    check("other_brk_value", value, 16'hE075);

    // parity error
    bv0 = bv_count; fe0 = fe_count;
    send_byte(8'h1C, 1'b1);
    check("par_fe", fe_count - fe0, 1);
    check("par_no_bv", bv_count - bv0, 0);
    check("par_keyDown", keyDown, 0);
    check("par_value", value, 16'hE075);
    send_byte(8'h1C, 1'b0);
    check("after_par_value", value, 16'h001C);
    check("after_par_keyDown", keyDown, 0);

    // typematic repeat, then a new make while held
    send_byte(8'h1C, 1'b0);
    check("repeat_value", value, 16'h001C);
    check("repeat_keyDown", keyDown, 0);
    send_byte(8'h75, 1'b0);
    check("newmake_value", value, 16'h0075);
    check("newmake_keyDown", keyDown, 0);

    // timeout after 5 bits
    bv0 = bv_count; fe0 = fe_count;
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
    wait_cycles(TO + 10);
    check("to_fe", fe_count - fe0, 1);
    check("to_no_bv", bv_count - bv0, 0);
    send_byte(8'h1C, 1'b0);
    check("after_to_value", value, 16'h001C);
    check("after_to_rxByte", rxByte, 8'h1C);

    // reset mid-frame after 6 bits
    send_bits({1'b1, 1'b0, 8'h75, 1'b0}, 6);
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(1);
    check("mid_rst_keyDown", keyDown, 1);
    check("mid_rst_value", value, 16'h0000);
    check("mid_rst_rxByte", rxByte, 8'h00);
    check("mid_rst_byteValid", byteValid, 0);
    check("mid_rst_frameError", frameError, 0);

    // single-cycle glitch on the clock line
    bv0 = bv_count; fe0 = fe_count;
    ps2Clk = 1'b0;
    wait_cycles(1);
    ps2Clk = 1'b1;
    wait_cycles(TO + 10);
    check("glitch_no_bv", bv_count - bv0, 0);
    check("glitch_no_fe", fe_count - fe0, 0);
    send_byte(8'h1C, 1'b0);
    check("post_rst_value", value, 16'h001C);
    check("post_rst_keyDown", keyDown, 0);
    check("post_rst_bv", bv_count - bv0, 1);

    check("no_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- Receives raw PS/2 keyboard frames on the ps2 clock/data lines and decodes scan codes.
- Produces the active-low key-held level and the 16-bit key value consumed directly by the keyboard interrupt stage.
- Tracks make, break (F0) and extended (E0) prefixes.
- Detects framing, parity and timeout errors.

Parameters:
- FILTER_LEN, 4: number of consecutive identical synchronized ps2Clk samples required to accept a level change (glitch filter).
- TIMEOUT_CYCLES, 50000: clk cycles without a falling ps2 clock edge, mid-frame, after which the partial frame is discarded.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- ps2Clk  input  1  raw PS/2 clock line, asynchronous
- ps2Data  input  1  raw PS/2 data line, asynchronous
- keyDown  output  1  active-low; 0 while the key reported in value is held
- value  output  16  {prefix, code}: prefix = 8'hE0 for extended keys, else 8'h00
- byteValid  output  1  one-cycle pulse when a good frame's data byte is accepted
- rxByte  output  8  last accepted data byte, including prefixes; held between pulses
- frameError  output  1  one-cycle pulse on start, parity or stop error, or on timeout

Behaviour:
- Reset values: keyDown=1, value=16'h0000, byteValid=0, rxByte=8'h00, frameError=0.
- Reset also clears all internal state: bit counter=0, shift register=0, e0Flag=0, f0Flag=0, filter state=1, timeout counter=0.
- Reset asserted mid-frame abandons the frame. The next frame is received from its start bit.

Input path:
- ps2Clk and ps2Data each pass through a 2-FF synchronizer.
- Filtered clock changes level only after FILTER_LEN equal synchronized samples.
- A falling edge is filtered clock going 1->0 between consecutive cycles. Call this cycle N.

Receive FSM, states IDLE, RECV, CHECK:
- IDLE: on a falling edge, sample synchronized ps2Data as the start bit, set bitCnt=1, go to RECV.
- RECV: each falling edge shifts ps2Data into an 11-bit register, LSB first, and increments bitCnt.
- RECV: when bitCnt reaches 11 on an edge at cycle N, go to CHECK at N+1.
- RECV: the timeout counter resets on every edge. If it reaches TIMEOUT_CYCLES, pulse frameError, go to IDLE, bitCnt=0.
- CHECK (cycle N+1): frame is valid iff start==0, stop==1, and XOR(data[7:0], parity)==1 (odd parity).
- CHECK, valid: at N+2, byteValid=1 and rxByte=data.
- CHECK, invalid: at N+2, frameError=1; decode flags unchanged.
- CHECK always returns to IDLE.

Decoder (acts on the valid byte in the same cycle as byteValid, so outputs are updated at N+2):
- 8'hE0: set e0Flag; no output change.
- 8'hF0: set f0Flag; no output change.
- Any other code c, with f0Flag==0 (make): value={e0Flag?8'hE0:8'h00, c}; keyDown=0; clear both flags.
- Any other code c, with f0Flag==1 (break): if {prefix, c}==value, keyDown=1; otherwise no output change. value is held either way. Clear both flags.
- Typematic repeat (same make again): value unchanged, keyDown stays 0.
- New make while another key is held: value switches to the new key, keyDown stays 0.
- Break of a non-current key is ignored.

Other rules:
- byteValid and frameError are never asserted in the same cycle.
- Each is a single-cycle pulse.
- Outputs are stable between frames so the downstream stage may sample at any time.

Test Plan:
- Make 'A' frame: start 0, data 0x1C LSB first, parity 0, stop 1 -> byteValid pulse with rxByte=8'h1C, then keyDown=0 and value=16'h001C exactly 2 clk after the 11th falling edge.
- Break sequence F0 (parity 1) then 1C after the 'A' make -> keyDown returns to 1, value stays 16'h001C, two byteValid pulses, no frameError.
- Extended up-arrow E0,75 -> value=16'hE075, keyDown=0. Then E0,F0,75 -> keyDown=1. Break 1C while E075 is held -> ignored, keyDown stays 0.
- Frame 0x1C with parity bit 1 -> frameError pulse, no byteValid, keyDown and value unchanged. A following valid frame decodes normally.
- 5 bits sent, then line idle for TIMEOUT_CYCLES+10 -> frameError pulse, FSM in IDLE. The next complete 0x1C frame yields value=16'h001C.
- rst pulsed after bit 6 of a frame, and a 1-cycle ps2Clk glitch injected (shorter than FILTER_LEN) -> all outputs at reset values, glitch ignored, subsequent frame received correctly.
